// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared constants and state type for the FIFO matrix-vector engine
package matvec_pkg;

    localparam int DEF_NUM_ROWS   = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int CNT_WIDTH      = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_matvec_engine_if.sv
// rtl/fifo_matvec_engine_if.sv - FIFO-side and result signals of the matrix-vector engine
interface fifo_matvec_engine_if
    import matvec_pkg::*;
#(
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
);
    logic                           start;
    logic [NUM_ROWS*DATA_WIDTH-1:0] row_data;
    logic [NUM_ROWS-1:0]            row_empty;
    logic [DATA_WIDTH-1:0]          vec_data;
    logic                           vec_empty;
    logic [NUM_ROWS-1:0]            row_rd_en;
    logic                           vec_rd_en;
    logic                           busy;
    logic                           done;
    logic [NUM_ROWS*ACC_WIDTH-1:0]  result;

    modport master (
        output start, row_data, row_empty, vec_data, vec_empty,
        input  row_rd_en, vec_rd_en, busy, done, result
    );

    modport slave (
        input  start, row_data, row_empty, vec_data, vec_empty,
        output row_rd_en, vec_rd_en, busy, done, result
    );

endinterface

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - unsigned multiply-accumulate lane with synchronous clear
module mac_lane
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);
    logic [2*DATA_WIDTH-1:0] prod;

    assign prod = a * b;

    // Sum wraps modulo 2^ACC_WIDTH; product is zero-extended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/fifo_matvec_engine.sv
// rtl/fifo_matvec_engine.sv - drains row and vector FIFOs in lock-step, one dot product per row
module fifo_matvec_engine
    import matvec_pkg::*;
#(
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_matvec_engine_if.slave  bus
);
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            all_ready;
    logic            pop;
    logic            clr;

    assign all_ready = ~|bus.row_empty & ~bus.vec_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                pop = all_ready;
                if (pop && (cnt_q == LAST)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One pop strobe fans out to every FIFO so partial pops cannot occur.
    assign bus.row_rd_en = {NUM_ROWS{pop}};
    assign bus.vec_rd_en = pop;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (pop),
            .a     (bus.row_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .b     (bus.vec_data),
            .acc   (bus.result[i*ACC_WIDTH +: ACC_WIDTH])
        );
    end

endmodule

// File: tb/tb_fifo_matvec_engine.sv
// tb/tb_fifo_matvec_engine.sv - self-checking bench with FIFO emulation and dot-product model
module tb_fifo_matvec_engine;
    import matvec_pkg::*;

    localparam int NR = 8;
    localparam int D  = 8;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int MEM = 512;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_matvec_engine_if #(.NUM_ROWS(NR), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    fifo_matvec_engine #(
        .NUM_ROWS(NR), .DEPTH(D), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] rmem [NR][MEM];
    logic [DW-1:0] vmem [MEM];
    int rwp [NR] = '{default: 0};
    int rrp [NR] = '{default: 0};
    int vwp = 0;
    int vrp = 0;
    logic [NR-1:0] hold_row = '0;
    logic          hold_vec = 1'b0;
    int flush_cnt  = 0;
    int flush_seen = 0;
    int pop_cnt      = 0;
    int partial_viol = 0;
    int empty_viol   = 0;

    int unsigned   cur_mat [NR][D];
    int unsigned   cur_vec [D];
    logic [AW-1:0] exp_res [NR];

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus.row_data[i*DW +: DW] = rmem[i][rrp[i]];
            bus.row_empty[i]         = (rrp[i] >= rwp[i]) || hold_row[i];
        end
        bus.vec_data  = vmem[vrp];
        bus.vec_empty = (vrp >= vwp) || hold_vec;
    end

    // FIFO side: pop on the strobes seen at the edge, then log protocol violations.
    always @(posedge clk) begin
        logic [NR-1:0] r, re;
        logic v, ve;
        r  = bus.row_rd_en;
        v  = bus.vec_rd_en;
        re = bus.row_empty;
        ve = bus.vec_empty;
        #1;
        if ((r != '0 && r != '1) || (v != (&r))) partial_viol++;
        if ((v && ve) || (|(r & re))) empty_viol++;
        for (int i = 0; i < NR; i++) if (r[i]) rrp[i]++;
        if (v) begin
            vrp++;
            pop_cnt++;
        end
        if (flush_cnt != flush_seen) begin
            for (int i = 0; i < NR; i++) rrp[i] = rwp[i];
            vrp = vwp;
            flush_seen = flush_cnt;
        end
    end

    task automatic push_op();
        for (int k = 0; k < D; k++) begin
            for (int i = 0; i < NR; i++) begin
                rmem[i][rwp[i]] = cur_mat[i][k][DW-1:0];
                rwp[i]++;
            end
            vmem[vwp] = cur_vec[k][DW-1:0];
            vwp++;
        end
        for (int i = 0; i < NR; i++) begin
            longint s = 0;
            for (int k = 0; k < D; k++) s += longint'(cur_mat[i][k]) * longint'(cur_vec[k]);
            exp_res[i] = AW'(s % (64'd1 << AW));
        end
    endtask

    task automatic rand_op();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < D; k++) cur_mat[i][k] = $urandom_range(0, 255);
        for (int k = 0; k < D; k++) cur_vec[k] = $urandom_range(0, 255);
        push_op();
    endtask

    task automatic run_op(input int glitch, output int lat, output bit to);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        to  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            bus.start = (lat == glitch);
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.row_rd_en !== '0 || bus.vec_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_en: row=%h vec=%b required 0", bus.row_rd_en, bus.vec_rd_en);
        end
        n_checks++;
        if (bus.result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h required 0", bus.result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int p0;
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < D; k++) cur_mat[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < D; k++) cur_vec[k] = k + 1;
        push_op();
        @(negedge clk);
        bus.start = 1'b1;
        p0 = pop_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= D; c++) begin
            n_checks++;
            if (bus.row_rd_en !== '1 || bus.vec_rd_en !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL identity_pop_c%0d: row=%h vec=%b done=%b required ff 1 0", c, bus.row_rd_en, bus.vec_rd_en, bus.done);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.row_rd_en !== '0 || pop_cnt - p0 != D) begin
            n_fail++;
            $display("FAIL identity_done_at_9: done=%b rd=%h pops=%0d required 1 0 %0d", bus.done, bus.row_rd_en, pop_cnt - p0, D);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (bus.result[i*AW +: AW] !== AW'(i + 1)) begin
                n_fail++;
                $display("FAIL identity_lane%0d: got %0d required %0d", i, bus.result[i*AW +: AW], i + 1);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_done_pulse: done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_max();
        int lat;
        bit to;
        logic [NR*AW-1:0] snap;
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < D; k++) cur_mat[i][k] = 255;
        for (int k = 0; k < D; k++) cur_vec[k] = 255;
        push_op();
        run_op(-1, lat, to);
        n_checks++;
        if (to || lat != D + 1) begin
            n_fail++;
            $display("FAIL max_latency: got %0d timeout=%b required %0d", lat, to, D + 1);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (bus.result[i*AW +: AW] !== 24'h07F008) begin
                n_fail++;
                $display("FAIL max_lane%0d: got %h required 07f008", i, bus.result[i*AW +: AW]);
            end
        end
        snap = bus.result;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.result !== snap || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL max_hold_idle: result=%h busy=%b required %h 0", bus.result, bus.busy, snap);
        end
    endtask

    task automatic test_stall();
        int p0, lat;
        bit to, stalled;
        logic [NR*AW-1:0] snap;
        rand_op();
        @(negedge clk);
        bus.start = 1'b1;
        p0 = pop_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        to = 1'b1;
        stalled = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            if (!stalled && pop_cnt - p0 == 4) begin
                stalled = 1'b1;
                hold_vec = 1'b1;
                snap = bus.result;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    n_checks++;
                    if (bus.row_rd_en !== '0 || bus.vec_rd_en !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_rd_en_s%0d: row=%h vec=%b required 0", s, bus.row_rd_en, bus.vec_rd_en);
                    end
                    @(negedge clk);
                    lat++;
                    n_checks++;
                    if (pop_cnt - p0 != 4 || bus.result !== snap) begin
                        n_fail++;
                        $display("FAIL stall_no_acc_s%0d: pops=%0d required 4, result changed=%b", s, pop_cnt - p0, bus.result !== snap);
                    end
                end
                hold_vec = 1'b0;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        n_checks++;
        if (to || lat != D + 4) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d timeout=%b required %0d", lat, to, D + 4);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (bus.result[i*AW +: AW] !== exp_res[i]) begin
                n_fail++;
                $display("FAIL stall_lane%0d: got %0d required %0d", i, bus.result[i*AW +: AW], exp_res[i]);
            end
        end
    endtask

    task automatic test_row_empty();
        int p0, lat;
        bit to;
        rand_op();
        hold_row = 8'b0000_1000;
        @(negedge clk);
        bus.start = 1'b1;
        p0 = pop_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (bus.row_rd_en !== '0 || bus.vec_rd_en !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL row_empty_c%0d: row=%h vec=%b busy=%b required 0 0 1", c, bus.row_rd_en, bus.vec_rd_en, bus.busy);
            end
            @(negedge clk);
        end
        n_checks++;
        if (pop_cnt != p0) begin
            n_fail++;
            $display("FAIL row_empty_pops: got %0d required 0", pop_cnt - p0);
        end
        hold_row = '0;
        lat = 0;
        to = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (to || lat != D) begin
            n_fail++;
            $display("FAIL row_empty_resume: cycles %0d timeout=%b required %0d", lat, to, D);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (bus.result[i*AW +: AW] !== exp_res[i]) begin
                n_fail++;
                $display("FAIL row_empty_lane%0d: got %0d required %0d", i, bus.result[i*AW +: AW], exp_res[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_a [NR];
        int lat;
        bit to;
        rand_op();
        exp_a = exp_res;
        rand_op();
        run_op(3, lat, to);
        n_checks++;
        if (to || lat != D + 1) begin
            n_fail++;
            $display("FAIL b2b_first_latency: got %0d timeout=%b required %0d", lat, to, D + 1);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (bus.result[i*AW +: AW] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL b2b_first_lane%0d: got %0d required %0d", i, bus.result[i*AW +: AW], exp_a[i]);
            end
        end
        run_op(-1, lat, to);
        n_checks++;
        if (to || lat != D + 1) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got %0d timeout=%b required %0d", lat, to, D + 1);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (bus.result[i*AW +: AW] !== exp_res[i]) begin
                n_fail++;
                $display("FAIL b2b_second_lane%0d: got %0d required %0d", i, bus.result[i*AW +: AW], exp_res[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int p0, lat;
        bit to, reached;
        rand_op();
        @(negedge clk);
        bus.start = 1'b1;
        p0 = pop_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (pop_cnt - p0 >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!reached || pop_cnt - p0 != 5) begin
            n_fail++;
            $display("FAIL midrun_pops: got %0d required 5", pop_cnt - p0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.result !== '0 || bus.busy !== 1'b0 || bus.row_rd_en !== '0 || bus.vec_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: result=%h busy=%b row=%h vec=%b required all 0", bus.result, bus.busy, bus.row_rd_en, bus.vec_rd_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        flush_cnt++;
        repeat (2) @(negedge clk);
        rand_op();
        run_op(-1, lat, to);
        n_checks++;
        if (to || lat != D + 1) begin
            n_fail++;
            $display("FAIL midrun_rerun_latency: got %0d timeout=%b required %0d", lat, to, D + 1);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (bus.result[i*AW +: AW] !== exp_res[i]) begin
                n_fail++;
                $display("FAIL midrun_rerun_lane%0d: got %0d required %0d", i, bus.result[i*AW +: AW], exp_res[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        for (int op = 0; op < 4; op++) begin
            rand_op();
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            lat = 1;
            to = 1'b1;
            for (int k = 0; k < 300; k++) begin
                if (bus.done) begin
                    to = 1'b0;
                    break;
                end
                hold_row = ($urandom_range(0, 3) == 0) ? (NR'(1) << $urandom_range(0, NR - 1)) : '0;
                hold_vec = ($urandom_range(0, 4) == 0);
                @(negedge clk);
                lat++;
            end
            hold_row = '0;
            hold_vec = 1'b0;
            n_checks++;
            if (to || lat < D + 1) begin
                n_fail++;
                $display("FAIL random_op%0d_latency: got %0d timeout=%b required >= %0d", op, lat, to, D + 1);
            end
            for (int i = 0; i < NR; i++) begin
                n_checks++;
                if (bus.result[i*AW +: AW] !== exp_res[i]) begin
                    n_fail++;
                    $display("FAIL random_op%0d_lane%0d: got %0d required %0d", op, i, bus.result[i*AW +: AW], exp_res[i]);
                end
            end
        end
        n_checks++;
        if (partial_viol != 0 || empty_viol != 0) begin
            n_fail++;
            $display("FAIL pop_protocol: partial=%0d pop_on_empty=%0d required 0 0", partial_viol, empty_viol);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_identity();
        test_max();
        test_stall();
        test_row_empty();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
